decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction decode stage between fetch and the immediate extender / register file.
- Accepts a fetched 36-bit instruction word plus PC over a valid/ready handshake.
- Splits the word into opcode, register specifiers, a raw 14-bit immediate field and the 2-bit immediate-type select consumed by the immediate extender.
- Contains a 2-entry skid buffer so that upstream ready is fully registered.

Parameters:
- INSTR_WIDTH, 36, instruction word width.
- PC_WIDTH, 16, program counter width.
- OPCODE_WIDTH, 6, opcode field width.
- REG_ADDR_WIDTH, 4, register specifier width.
- IMM_MAX_WIDTH, 14, raw immediate width presented downstream.
- SELECT_WIDTH, 2, immediate select width.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous pipeline flush (branch/jump redirect).
- i_valid  input  1  upstream instruction valid.
- i_instr  input  INSTR_WIDTH  instruction word.
- i_pc  input  PC_WIDTH  PC of i_instr.
- o_ready  output  1  stage can accept; registered.
- o_valid  output  1  decoded instruction valid.
- i_ready  input  1  downstream accepts.
- o_opcode  output  OPCODE_WIDTH  instr[35:30].
- o_rd  output  REG_ADDR_WIDTH  instr[29:26].
- o_rs1  output  REG_ADDR_WIDTH  instr[25:22].
- o_rs2  output  REG_ADDR_WIDTH  instr[21:18].
- o_immRaw  output  IMM_MAX_WIDTH  raw immediate field for the extender.
- o_immSel  output  SELECT_WIDTH  00 none, 01 I-type, 10 J-type.
- o_pc  output  PC_WIDTH  PC of the decoded instruction.
- o_illegal  output  1  opcode class reserved.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values:
  - o_valid=0, skid entry empty, o_ready=1.
  - All data outputs (o_opcode, o_rd, o_rs1, o_rs2, o_immRaw, o_immSel, o_pc, o_illegal) = 0.
- Priority per cycle: i_rst > i_flush > normal operation.
- Decode (combinational on i_instr, result captured into a register). The class is taken from opcode[5:4]:
  - 00 R-type: immSel=00, immRaw=0 regardless of the low bits.
  - 01 I-type: immSel=01, immRaw={6'b0, instr[7:0]}.
  - 10 J-type: immSel=10, immRaw=instr[13:0].
  - 11 reserved: immSel=00, immRaw=0, illegal=1. Still passed downstream as valid; no exception handling here.
- Transfer rules:
  - Accept when i_valid && o_ready.
  - Output consumed when o_valid && i_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when the output register is empty or consumed in the same cycle.
- Skid buffer:
  - If an accept occurs while the output register holds an unconsumed entry, the decoded entry goes to the skid register. o_ready goes to 0 the following cycle.
  - When the output is consumed and the skid is full, the skid moves to the output register and the skid clears. o_ready returns to 1 the following cycle.
  - If the output is consumed, the skid is full and an accept occurs in the same cycle, that accept is impossible because o_ready=0 while the skid is full.
- Ready timing: o_ready = !skid_valid, driven from a flop. It never depends combinationally on i_ready or i_valid.
- Stall: while o_valid && !i_ready, all output fields hold stable.
- Order: strictly FIFO; no reordering or dropping except on flush.
- Flush:
  - o_valid=0 and skid cleared next cycle.
  - An instruction presented in the flush cycle is discarded even if i_valid && o_ready.
  - Data outputs are cleared to 0.
  - o_ready=1 next cycle.
- Reset mid-stall: identical to the reset values above; buffered entries are lost.

Test Plan:
- Reset then I-type: i_instr=0x4CD4000F0, i_pc=0x0010, i_ready=1 -> next cycle o_valid=1, o_opcode=0x13, o_rd=3, o_rs1=5, o_rs2=0, o_immSel=01, o_immRaw=0x00F0, o_pc=0x0010, o_illegal=0.
- J-type and R-type:
  - i_instr=0x800002ABC -> o_immSel=10, o_immRaw=0x2ABC.
  - i_instr=0x1448C0FFF -> o_opcode=0x05, o_rd=1, o_rs1=2, o_rs2=3, o_immSel=00, o_immRaw=0.
- Illegal: i_instr=0xFC0000123 -> o_illegal=1, o_immSel=00, o_immRaw=0, o_valid=1.
- Backpressure: i_ready=0, push A (pc 0x1) then B (pc 0x2) back-to-back -> o_ready=0 the cycle after B, outputs hold A.
  - Then i_ready=1 -> A consumed, B appears next cycle, o_ready=1 the cycle after.
  - No loss or duplication over 100 random-valid/random-ready cycles (scoreboard).
- Flush with A in output and B in skid, plus C presented in the flush cycle -> next cycle o_valid=0, o_ready=1, all data outputs 0. C never appears.
- Reset asserted mid-stall with skid full -> next cycle o_valid=0, o_ready=1, outputs 0. A subsequent instruction decodes normally with 1-cycle latency.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction decode stage with a 2-entry (output + skid) buffer.
// Upstream ready comes straight from a flop so it never sees downstream ready combinationally.
module decode_stage #(
    parameter int unsigned INSTR_WIDTH    = 36,
    parameter int unsigned PC_WIDTH       = 16,
    parameter int unsigned OPCODE_WIDTH   = 6,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned IMM_MAX_WIDTH  = 14,
    parameter int unsigned SELECT_WIDTH   = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [INSTR_WIDTH-1:0]    i_instr,
    input  logic [PC_WIDTH-1:0]       i_pc,
    output logic                      o_ready,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [OPCODE_WIDTH-1:0]   o_opcode,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [REG_ADDR_WIDTH-1:0] o_rs1,
    output logic [REG_ADDR_WIDTH-1:0] o_rs2,
    output logic [IMM_MAX_WIDTH-1:0]  o_immRaw,
    output logic [SELECT_WIDTH-1:0]   o_immSel,
    output logic [PC_WIDTH-1:0]       o_pc,
    output logic                      o_illegal
);

    localparam int unsigned OpLsb  = INSTR_WIDTH - OPCODE_WIDTH;
    localparam int unsigned RdLsb  = OpLsb - REG_ADDR_WIDTH;
    localparam int unsigned Rs1Lsb = RdLsb - REG_ADDR_WIDTH;
    localparam int unsigned Rs2Lsb = Rs1Lsb - REG_ADDR_WIDTH;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [IMM_MAX_WIDTH-1:0]  imm_raw;
        logic [SELECT_WIDTH-1:0]   imm_sel;
        logic [PC_WIDTH-1:0]       pc;
        logic                      illegal;
    } entry_t;

    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;
    logic   r_ready;

    entry_t w_dec;
    entry_t w_out_next;
    entry_t w_skid_next;
    logic   w_out_valid_next;
    logic   w_skid_valid_next;
    logic   w_accept;
    logic   w_consume;
    logic   w_unused_bits;

    // Bits between the register specifiers and the immediate field are not decoded here.
    assign w_unused_bits = ^i_instr[Rs2Lsb-1:IMM_MAX_WIDTH];

    assign w_accept  = i_valid && r_ready;
    assign w_consume = r_out_valid && i_ready;

    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = i_instr[INSTR_WIDTH-1:OpLsb];
        w_dec.rd      = i_instr[OpLsb-1:RdLsb];
        w_dec.rs1     = i_instr[RdLsb-1:Rs1Lsb];
        w_dec.rs2     = i_instr[Rs1Lsb-1:Rs2Lsb];
        w_dec.pc      = i_pc;
        case (i_instr[INSTR_WIDTH-1 -: 2])
            2'b01: begin
                w_dec.imm_sel = SELECT_WIDTH'(1);
                w_dec.imm_raw = {{(IMM_MAX_WIDTH-8){1'b0}}, i_instr[7:0]};
            end
            2'b10: begin
                w_dec.imm_sel = SELECT_WIDTH'(2);
                w_dec.imm_raw = i_instr[IMM_MAX_WIDTH-1:0];
            end
            2'b11: begin
                w_dec.illegal = 1'b1;
            end
            default: begin
                w_dec.imm_sel = '0;
            end
        endcase
    end

    always_comb begin
        w_out_next        = r_out;
        w_out_valid_next  = r_out_valid;
        w_skid_next       = r_skid;
        w_skid_valid_next = r_skid_valid;
        if (i_flush) begin
            w_out_next        = '0;
            w_out_valid_next  = 1'b0;
            w_skid_next       = '0;
            w_skid_valid_next = 1'b0;
        end else if (!r_out_valid || w_consume) begin
            // Output slot frees up: the skid entry is older, so it always wins.
            if (r_skid_valid) begin
                w_out_next        = r_skid;
                w_out_valid_next  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_out_next       = w_dec;
                w_out_valid_next = 1'b1;
            end else begin
                w_out_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_next       = w_dec;
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_out        <= w_out_next;
            r_skid       <= w_skid_next;
            r_out_valid  <= w_out_valid_next;
            r_skid_valid <= w_skid_valid_next;
            r_ready      <= !w_skid_valid_next;
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_out_valid;
    assign o_opcode  = r_out.opcode;
    assign o_rd      = r_out.rd;
    assign o_rs1     = r_out.rs1;
    assign o_rs2     = r_out.rs2;
    assign o_immRaw  = r_out.imm_raw;
    assign o_immSel  = r_out.imm_sel;
    assign o_pc      = r_out.pc;
    assign o_illegal = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random handshake traffic against a queue model.
module tb_decode_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        i_valid;
    logic [35:0] i_instr;
    logic [15:0] i_pc;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_opcode;
    logic [3:0]  o_rd;
    logic [3:0]  o_rs1;
    logic [3:0]  o_rs2;
    logic [13:0] o_immRaw;
    logic [1:0]  o_immSel;
    logic [15:0] o_pc;
    logic        o_illegal;

    decode_stage u_dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .i_instr   (i_instr),
        .i_pc      (i_pc),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_opcode  (o_opcode),
        .o_rd      (o_rd),
        .o_rs1     (o_rs1),
        .o_rs2     (o_rs2),
        .o_immRaw  (o_immRaw),
        .o_immSel  (o_immSel),
        .o_pc      (o_pc),
        .o_illegal (o_illegal)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [13:0] imm;
        logic [1:0]  sel;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    bit   zero_out = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [35:0] ins, input logic [15:0] pc);
        exp_t        e;
        longint unsigned w;
        int unsigned cls;
        w     = longint'(ins);
        e.op  = 6'(w >> 30);
        e.rd  = 4'((w >> 26) % 16);
        e.rs1 = 4'((w >> 22) % 16);
        e.rs2 = 4'((w >> 18) % 16);
        e.pc  = pc;
        e.sel = 2'd0;
        e.imm = 14'd0;
        e.ill = 1'b0;
        cls   = int'(e.op) / 16;
        if (cls == 1) begin
            e.sel = 2'd1;
            e.imm = 14'(w % 256);
        end else if (cls == 2) begin
            e.sel = 2'd2;
            e.imm = 14'(w % 16384);
        end else if (cls == 3) begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Stage holds up to two instructions in order; ready means fewer than two are held.
    task automatic model_update();
        bit cons;
        bit acc;
        if (i_rst || i_flush) begin
            q.delete();
            zero_out = 1'b1;
        end else begin
            cons = (q.size() > 0) && i_ready;
            acc  = i_valid && (q.size() < 2);
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(i_instr, i_pc));
            if (q.size() > 0) zero_out = 1'b0;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        check_eq("valid", 64'(o_valid), 64'(q.size() > 0));
        check_eq("ready", 64'(o_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            check_eq("opcode", 64'(o_opcode), 64'(e.op));
            check_eq("rd", 64'(o_rd), 64'(e.rd));
            check_eq("rs1", 64'(o_rs1), 64'(e.rs1));
            check_eq("rs2", 64'(o_rs2), 64'(e.rs2));
            check_eq("immRaw", 64'(o_immRaw), 64'(e.imm));
            check_eq("immSel", 64'(o_immSel), 64'(e.sel));
            check_eq("pc", 64'(o_pc), 64'(e.pc));
            check_eq("illegal", 64'(o_illegal), 64'(e.ill));
        end else if (zero_out) begin
            check_eq("zero_data", 64'({o_opcode, o_rd, o_rs1, o_rs2, o_immRaw, o_immSel, o_pc,
                                      o_illegal}), 64'd0);
        end
    endtask

    // Inputs are set at the falling edge, so each step samples them on the next rising edge.
    task automatic step();
        model_update();
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [35:0] ins, input logic [15:0] pc,
                         input logic rdy);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
        i_ready = rdy;
    endtask

    function automatic logic [35:0] rand_instr();
        return {4'($urandom), 32'($urandom)};
    endfunction

    initial begin
        i_rst   = 1'b1;
        i_flush = 1'b0;
        drive(1'b0, 36'd0, 16'd0, 1'b1);
        @(negedge i_clk);
        step();
        step();
        i_rst = 1'b0;

        drive(1'b1, 36'h4CD4000F0, 16'h0010, 1'b1);
        step();
        check_eq("itype_valid", 64'(o_valid), 64'd1);
        check_eq("itype_op", 64'(o_opcode), 64'h13);
        check_eq("itype_rd", 64'(o_rd), 64'd3);
        check_eq("itype_rs1", 64'(o_rs1), 64'd5);
        check_eq("itype_rs2", 64'(o_rs2), 64'd0);
        check_eq("itype_sel", 64'(o_immSel), 64'd1);
        check_eq("itype_imm", 64'(o_immRaw), 64'h00F0);
        check_eq("itype_pc", 64'(o_pc), 64'h0010);
        check_eq("itype_ill", 64'(o_illegal), 64'd0);

        drive(1'b1, 36'h800002ABC, 16'h0014, 1'b1);
        step();
        check_eq("jtype_sel", 64'(o_immSel), 64'd2);
        check_eq("jtype_imm", 64'(o_immRaw), 64'h2ABC);

        drive(1'b1, 36'h1448C0FFF, 16'h0018, 1'b1);
        step();
        check_eq("rtype_op", 64'(o_opcode), 64'h05);
        check_eq("rtype_regs", 64'({o_rd, o_rs1, o_rs2}), 64'h123);
        check_eq("rtype_sel", 64'(o_immSel), 64'd0);
        check_eq("rtype_imm", 64'(o_immRaw), 64'd0);

        drive(1'b1, 36'hFC0000123, 16'h001C, 1'b1);
        step();
        check_eq("illegal_flag", 64'(o_illegal), 64'd1);
        check_eq("illegal_valid", 64'(o_valid), 64'd1);
        check_eq("illegal_sel_imm", 64'({o_immSel, o_immRaw}), 64'd0);
        drive(1'b0, 36'd0, 16'd0, 1'b1);
        step();

        // Backpressure: A then B back-to-back into a stalled stage.
        drive(1'b1, rand_instr(), 16'h0001, 1'b0);
        step();
        drive(1'b1, rand_instr(), 16'h0002, 1'b0);
        step();
        check_eq("bp_ready_low", 64'(o_ready), 64'd0);
        check_eq("bp_hold_a", 64'(o_pc), 64'h0001);
        drive(1'b0, 36'd0, 16'd0, 1'b0);
        step();
        check_eq("bp_still_a", 64'(o_pc), 64'h0001);
        i_ready = 1'b1;
        step();
        check_eq("bp_b_out", 64'(o_pc), 64'h0002);
        check_eq("bp_ready_back", 64'(o_ready), 64'd1);
        step();

        // Flush with A in output, B in skid and C presented in the flush cycle.
        drive(1'b1, rand_instr(), 16'h00A0, 1'b0);
        step();
        drive(1'b1, rand_instr(), 16'h00B0, 1'b0);
        step();
        drive(1'b1, 36'h4CD4000F0, 16'h00C0, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check_eq("flush_valid", 64'(o_valid), 64'd0);
        check_eq("flush_ready", 64'(o_ready), 64'd1);
        check_eq("flush_pc", 64'(o_pc), 64'd0);
        drive(1'b0, 36'd0, 16'd0, 1'b1);
        for (int i = 0; i < 3; i++) step();

        // Reset while stalled with the skid full.
        drive(1'b1, rand_instr(), 16'h0D01, 1'b0);
        step();
        drive(1'b1, rand_instr(), 16'h0D02, 1'b0);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        drive(1'b1, 36'h800002ABC, 16'h0D03, 1'b1);
        step();
        check_eq("post_rst_pc", 64'(o_pc), 64'h0D03);
        check_eq("post_rst_imm", 64'(o_immRaw), 64'h2ABC);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom % 2), rand_instr(), 16'($urandom), 1'($urandom_range(0, 3) != 0));
            i_flush = ($urandom_range(0, 39) == 0);
            step();
        end
        i_flush = 1'b0;
        drive(1'b0, 36'd0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
